uart_rx_core: RTL and testbench

Parametrised UART receive engine that replaces the fixed 11-bit-frame receiver in the APB UART controller. It adds oversampled start-bit validation, 3-vote majority sampling, runtime-selectable parity and stop-bit count, and a valid/ready output register with overrun, framing, parity and break reporting. It sits between the pad-side `rx` line and the APB register/FIFO layer, and is driven by the shared baud generator's oversample tick.

---
 rtl/uart_rx_core.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receive engine with 3-vote majority
// sampling, runtime parity / stop-bit selection and a valid/ready output
// register that reports overrun, framing, parity and break conditions.
//
// Output handshake: rx_valid is high while the output register holds an
// unread frame; the frame is consumed on the clk edge where rx_valid and
// rx_ready are both high. rx_data/rx_err are only meaningful while rx_valid
// is high. A frame that completes while the register is full and not being
// read is dropped and signalled by a one-cycle overrun pulse.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [2:0]           rx_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic [2:0]           dbg_state_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Vote positions around mid-bit and the last tick of a bit period.
  localparam logic [CW-1:0] VOTE0    = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] VOTE1    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] VOTE2    = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] TICK_END = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_e;

  logic                 sync1_q, sync2_q;
  logic                 rx_s;
  state_e               state_q, state_d;
  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop1_q, stop1_d;
  logic                 ferr_q, ferr_d;
  logic                 cfg_pe_q, cfg_pe_d;
  logic                 cfg_po_q, cfg_po_d;
  logic                 cfg_ts_q, cfg_ts_d;
  logic                 done;
  logic                 bit_val;
  logic                 mid_tick, end_tick;
  logic [2:0]           fin_err;

  logic [DATA_BITS-1:0] rx_data_q;
  logic [2:0]           rx_err_q;
  logic                 rx_valid_q;
  logic                 overrun_q;

  // Two-flop synchronizer on the asynchronous line; idles high out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s     = sync2_q;
  assign bit_val  = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
  assign mid_tick = baud_tick && (tick_cnt_q == VOTE2);
  assign end_tick = baud_tick && (tick_cnt_q == TICK_END);

  // Frame state register and per-frame datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      vote_q     <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop1_q    <= 1'b0;
      ferr_q     <= 1'b0;
      cfg_pe_q   <= 1'b0;
      cfg_po_q   <= 1'b0;
      cfg_ts_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      vote_q     <= vote_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop1_q    <= stop1_d;
      ferr_q     <= ferr_d;
      cfg_pe_q   <= cfg_pe_d;
      cfg_po_q   <= cfg_po_d;
      cfg_ts_q   <= cfg_ts_d;
    end
  end

  // Next-state logic: bit timing, majority voting and frame sequencing.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    vote_d     = vote_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop1_d    = stop1_q;
    ferr_d     = ferr_q;
    cfg_pe_d   = cfg_pe_q;
    cfg_po_d   = cfg_po_q;
    cfg_ts_d   = cfg_ts_q;
    done       = 1'b0;

    if (baud_tick && state_q != S_IDLE) begin
      tick_cnt_d = (tick_cnt_q == TICK_END) ? '0 : tick_cnt_q + 1'b1;
    end
    if (baud_tick && tick_cnt_q == VOTE0) vote_d[0] = rx_s;
    if (baud_tick && tick_cnt_q == VOTE1) vote_d[1] = rx_s;

    case (state_q)
      S_IDLE: begin
        if (baud_tick && !rx_s) begin
          // Configuration is frozen here for the whole frame.
          cfg_pe_d   = parity_en;
          cfg_po_d   = parity_odd;
          cfg_ts_d   = two_stop;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          ferr_d     = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (mid_tick && bit_val) begin
          tick_cnt_d = '0;
          state_d    = S_IDLE;
        end else if (end_tick) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (mid_tick) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
        if (end_tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = cfg_pe_q ? S_PARITY : S_STOP1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (mid_tick) par_d = bit_val;
        if (end_tick) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (mid_tick) begin
          stop1_d = bit_val;
          ferr_d  = ferr_q | ~bit_val;
          if (!cfg_ts_q) begin
            // Finishing at mid-bit lets the next start edge be caught early.
            done       = 1'b1;
            tick_cnt_d = '0;
            state_d    = S_IDLE;
          end
        end else if (end_tick) begin
          state_d = S_STOP2;
        end
      end
      S_STOP2: begin
        if (mid_tick) begin
          ferr_d     = ferr_q | ~bit_val;
          done       = 1'b1;
          tick_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        tick_cnt_d = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Error flags of the completing frame: {break, framing, parity}.
  assign fin_err[2] = ~(|shift_q) & (~cfg_pe_q | ~par_q) & ~stop1_d;
  assign fin_err[1] = ferr_d;
  assign fin_err[0] = cfg_pe_q & (^shift_q ^ par_q ^ cfg_po_q);

  // Output register with valid/ready handshake and overrun pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_q  <= '0;
      rx_err_q   <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_err_q   <= fin_err;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_err      = rx_err_q;
  assign rx_valid    = rx_valid_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: drives the line one oversample tick at a time,
// records the line per tick, and decodes it with a tick-indexed reference
// model to predict every delivered frame, its errors and its completion tick.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int DB = 8;
  localparam int O  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          baud_tick = 1'b0;
  logic          rx = 1'b1;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          two_stop = 1'b0;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic [2:0]    rx_err;
  logic          rx_valid;
  logic          overrun;
  logic [2:0]    dbg_state;

  uart_rx_core #(.DATA_BITS(DB), .OVERSAMPLE(O)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .two_stop    (two_stop),
    .rx_data     (rx_data),
    .rx_err      (rx_err),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .overrun     (overrun),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errs   = 0;
  int tk       = 0;
  int seg_start = 0;
  int ovr_seen = 0;
  int ovr_exp  = 0;
  bit ready_low_seg = 1'b0;
  bit line_a[$];
  bit pe_a[$];
  bit po_a[$];
  bit ts_a[$];
  // entry = {tick[19:0], err[2:0], data[7:0]}
  logic [30:0] exp_q[$];
  logic [30:0] obs_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h (tick %0d)", tag, got, exp, tk);
    end
  endtask

  // ---------------- monitor ----------------
  bit prev_valid = 1'b0;
  bit want_low   = 1'b0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      prev_valid = 1'b0;
      want_low   = 1'b0;
    end else begin
      if (overrun) ovr_seen++;
      if (want_low) begin
        check_eq("valid_width", 32'(rx_valid), 32'd0);
        want_low = 1'b0;
      end
      if (rx_valid && !prev_valid) begin
        obs_q.push_back({tk[19:0], rx_err, rx_data});
        if (rx_ready) want_low = 1'b1;
      end
      prev_valid = rx_valid;
    end
  end

  // ---------------- reference model ----------------
  function automatic bit maj(input int t);
    int s;
    s = int'(line_a[t]) + int'(line_a[t+1]) + int'(line_a[t+2]);
    return (s >= 2);
  endfunction

  // First vote tick of frame bit i (0 = start bit) for a start seen at tick d.
  function automatic int vote_at(input int d, input int i);
    return d + 1 + i * O + O / 2 - 1;
  endfunction

  function automatic void run_model(input int lo, input int hi);
    int k;
    int d;
    int nb;
    int tc;
    int ones;
    bit pe, po, ts, p, s1, s2, perr, ferr, brk;
    logic [7:0] data;
    k = lo;
    while (k < hi) begin
      if (line_a[k]) begin
        k++;
        continue;
      end
      d  = k;
      pe = pe_a[d];
      po = po_a[d];
      ts = ts_a[d];
      if (vote_at(d, 0) + 2 >= hi) break;
      if (maj(vote_at(d, 0))) begin
        k = vote_at(d, 0) + 3;
        continue;
      end
      nb = 1 + DB + int'(pe) + 1 + int'(ts);
      tc = vote_at(d, nb - 1) + 2;
      if (tc >= hi) break;
      for (int i = 0; i < DB; i++) data[i] = maj(vote_at(d, i + 1));
      p  = pe ? maj(vote_at(d, DB + 1)) : 1'b0;
      s1 = maj(vote_at(d, DB + 1 + int'(pe)));
      s2 = ts ? maj(vote_at(d, DB + 2 + int'(pe))) : 1'b1;
      ones = $countones(data) + int'(p);
      perr = pe && ((ones % 2) != int'(po));
      ferr = !s1 || !s2;
      brk  = (data == 8'h00) && !p && !s1;
      exp_q.push_back({tc[19:0], brk, ferr, perr, data});
      k = tc + 1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; one oversample tick every 3 clk cycles so the
  // synchronizer has settled on the new line value by the tick edge.
  task automatic do_tick(input bit v);
    rx = v;
    baud_tick = 1'b0;
    line_a.push_back(v);
    pe_a.push_back(parity_en);
    po_a.push_back(parity_odd);
    ts_a.push_back(two_stop);
    @(negedge clk);
    @(negedge clk);
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
    tk++;
  endtask

  task automatic idle(input int n);
    repeat (n) do_tick(1'b1);
  endtask

  task automatic low(input int n);
    repeat (n) do_tick(1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe, input bit po, input bit ts,
                            input bit pb, input bit s1, input bit s2, input int glitch,
                            input int max_ticks, input bit scramble);
    bit b[$];
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    b.push_back(1'b0);
    for (int i = 0; i < DB; i++) b.push_back(d[i]);
    if (pe) b.push_back(pb);
    b.push_back(s1);
    if (ts) b.push_back(s2);
    for (int i = 0; i < b.size(); i++) begin
      for (int c = 0; c < O; c++) begin
        int off;
        bit v;
        off = i * O + c;
        if (off >= max_ticks) return;
        if (scramble && off == O) begin
          parity_en  = 1'($urandom_range(0, 1));
          parity_odd = 1'($urandom_range(0, 1));
          two_stop   = 1'($urandom_range(0, 1));
        end
        v = b[i];
        if (off == glitch) v = ~v;
        do_tick(v);
      end
    end
  endtask

  task automatic send_simple(input logic [7:0] d, input bit pe, input bit po, input bit ts,
                             input bit pb, input bit s1, input bit s2);
    send_frame(d, pe, po, ts, pb, s1, s2, -1, 1 << 30, 1'b0);
  endtask

  task automatic expect_last(input string tag, input logic [7:0] d, input logic [2:0] e);
    check_eq({tag, "_seen"}, 32'(obs_q.size() > 0), 32'd1);
    if (obs_q.size() > 0) begin
      check_eq({tag, "_data"}, 32'(obs_q[obs_q.size()-1][7:0]), 32'(d));
      check_eq({tag, "_err"}, 32'(obs_q[obs_q.size()-1][10:8]), 32'(e));
    end
  endtask

  // Compares everything the DUT delivered since the last segment boundary
  // against the model's decoding of the line over the same ticks.
  task automatic end_segment(input bit flush);
    logic [30:0] o, e;
    if (flush) idle(13 * O);
    exp_q.delete();
    run_model(seg_start, tk);
    if (ready_low_seg) begin
      while (exp_q.size() > 1) begin
        void'(exp_q.pop_back());
        ovr_exp++;
      end
    end
    check_eq("frame_count", 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check_eq("frame_tick", 32'(o[30:11]), 32'(e[30:11]));
      check_eq("frame_data", 32'(o[7:0]), 32'(e[7:0]));
      check_eq("frame_err", 32'(o[10:8]), 32'(e[10:8]));
    end
    check_eq("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
    obs_q.delete();
    seg_start = tk;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    logic [7:0] d;
    bit pe, po, ts, pb, s1, s2;
    int nb, glitch, gap;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("reset_valid", 32'(rx_valid), 32'd0);
    check_eq("reset_data", 32'(rx_data), 32'd0);
    check_eq("reset_err", 32'(rx_err), 32'd0);
    check_eq("reset_overrun", 32'(overrun), 32'd0);
    idle(10);

    // 8N1 0xA5
    send_simple(8'hA5, 0, 0, 0, 0, 1, 1);
    expect_last("n1_a5", 8'hA5, 3'b000);
    idle(5);
    // 8E1 0x3C with wrong parity, then 8O2 with correct parity
    send_simple(8'h3C, 1, 0, 0, 1, 1, 1);
    expect_last("e1_bad_par", 8'h3C, 3'b001);
    send_simple(8'h3C, 1, 1, 1, 1, 1, 1);
    expect_last("o2_good", 8'h3C, 3'b000);
    idle(3);
    // 8N2 0x55 with second stop bit low, then a long break
    send_simple(8'h55, 0, 0, 1, 0, 1, 0);
    expect_last("n2_stop2", 8'h55, 3'b010);
    idle(20);
    low(12 * O);
    expect_last("break", 8'h00, 3'b110);
    idle(13 * O);
    // short low pulse is a false start
    n0 = obs_q.size();
    low(6);
    idle(30);
    check_eq("glitch_pulse", 32'(obs_q.size()), 32'(n0));
    // single-tick glitch on the centre vote of data bit 3
    send_frame(8'h00, 0, 0, 0, 0, 1, 1, 4 * O + O / 2 + 1, 1 << 30, 1'b0);
    expect_last("glitch_bit3", 8'h00, 3'b000);
    end_segment(1'b1);

    // overrun: consumer stalled across two back-to-back frames
    rx_ready = 1'b0;
    ready_low_seg = 1'b1;
    send_simple(8'h11, 0, 0, 0, 0, 1, 1);
    send_simple(8'h22, 0, 0, 0, 0, 1, 1);
    idle(20);
    check_eq("ovr_valid_held", 32'(rx_valid), 32'd1);
    check_eq("ovr_data_kept", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ovr_valid_drop", 32'(rx_valid), 32'd0);
    @(negedge clk);
    end_segment(1'b1);
    ready_low_seg = 1'b0;

    // reset during data bit 4 of 0xFF
    send_frame(8'hFF, 0, 0, 0, 0, 1, 1, -1, 5 * O + O / 2, 1'b0);
    end_segment(1'b0);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_mid_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_mid_data", 32'(rx_data), 32'd0);
    check_eq("rst_mid_err", 32'(rx_err), 32'd0);
    seg_start = tk;
    idle(10);
    send_simple(8'h81, 0, 0, 0, 0, 1, 1);
    expect_last("after_rst", 8'h81, 3'b000);
    end_segment(1'b1);

    // randomized frames, configs, gaps, glitches and false starts
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      pe = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      ts = 1'($urandom_range(0, 1));
      pb = (^d) ^ po;
      if ($urandom_range(0, 4) == 0) pb = ~pb;
      s1 = ($urandom_range(0, 7) != 0);
      s2 = ($urandom_range(0, 7) != 0);
      nb = 1 + DB + int'(pe) + 1 + int'(ts);
      glitch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb * O - 1)) : -1;
      send_frame(d, pe, po, ts, pb, s1, s2, glitch, 1 << 30, 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2) == 0 ? 0 : int'($urandom_range(1, 20));
      idle(gap);
      if ($urandom_range(0, 5) == 0) begin
        low($urandom_range(1, O / 2 - 1));
        idle(14);
      end
    end
    end_segment(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
